// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
//
// Host-side sequencer for one SPI memory transaction (SPI mode 0). A single
// cycle request (rw/addr/wdata) is latched, then one frame is generated:
//   8 bits   : addr[6:0] followed by rw, MSB first
//   TURN     : turnaround SCLK cycles (reads only, mosi held at 0)
//   8 bits   : wdata shifted out (write) or miso shifted in (read)
//   HOLD     : CLK_DIV clocks with cs low, sclk low
//   GAP      : CLK_DIV clocks with cs high; done pulses in the first one
//
// Parameters
//   CLK_DIV  system clocks per SCLK half-period (>= 1)
//   TURN     turnaround SCLK cycles between address byte and read data (>= 0)
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   start      request strobe, accepted while busy = 0
//   rw         1 = read, 0 = write (captured with start)
//   addr[6:0]  memory address (captured with start)
//   wdata[7:0] write data (captured with start)
//   busy       high from the cycle after acceptance until the end of GAP
//   done       one-cycle pulse at frame end
//   rdata[7:0] last read result, valid with done, held until the next read
//   cs         slave chip select, active low
//   sclk       serial clock, idles low
//   mosi       serial data to the slave
//   miso       serial data from the slave
//   dbg_state  current FSM state (IDLE=0 ADDR=1 TURNA=2 DATA=3 HOLD=4 GAP=5)
//
// Handshake: a request is taken on a rising edge where start = 1 and busy = 0;
// there is no back-pressure signal other than busy, and the request fields
// are ignored at every other edge.
//
// Build option SPI_MASTER_CTRL_QUEUE_EN: adds a one-entry request buffer. A
// start seen while busy is stored if the buffer is empty (dropped otherwise)
// and launched at the end of GAP without busy going low.
//
// All outputs are registered from the current state, so every output lags the
// state register by one clock: the state enters ADDR at the accepting edge
// and cs falls one cycle later.
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
  parameter int CLK_DIV = 2,
  parameter int TURN    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_TURNA = 3'd2,
    S_DATA  = 3'd3,
    S_HOLD  = 3'd4,
    S_GAP   = 3'd5
  } state_e;

  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_MAX = (TURN > 8) ? TURN : 8;
  localparam int BIT_W   = $clog2(BIT_MAX) + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(7);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [BIT_W-1:0] TURN_LAST = BIT_W'(TURN - 1);

  // FSM and counters
  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;      // clocks within a half-period
  logic               phase_q, phase_d;  // 0 = sclk low half, 1 = high half
  logic [BIT_W-1:0]   bit_q, bit_d;      // bit index within the current state

  // Latched request
  logic               rw_q, rw_d;
  logic [6:0]         addr_q, addr_d;
  logic [7:0]         wdata_q, wdata_d;

  // Receive path
  logic [7:0]         rx_q, rx_d;
  logic [7:0]         rdata_q, rdata_d;

  // Registered outputs
  logic               cs_q, cs_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Derived timing strobes
  logic               half_end;   // last clock of a half-period
  logic               bit_end;    // last clock of a full SCLK cycle
  logic               shifting;   // state drives sclk
  logic               rise_next;  // sclk goes 0->1 at the coming edge
  logic [2:0]         tx_idx;

  // Request sources
  logic               accept;
  logic               q_launch;
  logic               q_pending;
  logic               q_rw;
  logic [6:0]         q_addr;
  logic [7:0]         q_wdata;
  logic               load_req;

  assign half_end  = (div_q == DIV_LAST);
  assign bit_end   = phase_q && half_end;
  assign shifting  = (state_q == S_ADDR) || (state_q == S_TURNA) ||
                     (state_q == S_DATA);
  // First clock of the high half: the registered sclk rises at the end of it,
  // which is the edge at which miso is sampled.
  assign rise_next = shifting && phase_q && (div_q == '0);
  assign tx_idx    = 3'd7 - bit_q[2:0];

`ifdef SPI_MASTER_CTRL_QUEUE_EN
  logic       qv_q, qv_d;
  logic       q_store;
  logic       q_rw_q;
  logic [6:0] q_addr_q;
  logic [7:0] q_wdata_q;

  assign accept    = start && (state_q == S_IDLE) && !busy_q && !qv_q;
  assign q_store   = start && !accept && !qv_q;
  // The buffered request goes out at the end of GAP, or straight from IDLE
  // if it was stored in the last cycle before busy dropped.
  assign q_launch  = qv_q && ((state_q == S_IDLE) ||
                              ((state_q == S_GAP) && half_end));
  assign q_pending = qv_q;
  assign q_rw      = q_rw_q;
  assign q_addr    = q_addr_q;
  assign q_wdata   = q_wdata_q;

  always_comb begin
    qv_d = qv_q;
    if (q_launch) qv_d = 1'b0;
    if (q_store)  qv_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      qv_q      <= 1'b0;
      q_rw_q    <= 1'b0;
      q_addr_q  <= '0;
      q_wdata_q <= '0;
    end else begin
      qv_q <= qv_d;
      if (q_store) begin
        q_rw_q    <= rw;
        q_addr_q  <= addr;
        q_wdata_q <= wdata;
      end
    end
  end
`else
  assign accept    = start && (state_q == S_IDLE) && !busy_q;
  assign q_launch  = 1'b0;
  assign q_pending = 1'b0;
  assign q_rw      = 1'b0;
  assign q_addr    = '0;
  assign q_wdata   = '0;
`endif

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next state and counters
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept || q_launch) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (bit_end && (bit_q == BIT_LAST)) begin
          if (rw_q && (TURN != 0)) state_d = S_TURNA;
          else                     state_d = S_DATA;
        end
      end
      S_TURNA: begin
        if (bit_end && (bit_q == TURN_LAST)) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_q == BIT_LAST)) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (half_end) state_d = S_GAP;
      end
      S_GAP: begin
        if (half_end) state_d = q_launch ? S_ADDR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    if (state_d != state_q) begin
      // Every state starts with fresh counters.
      div_d   = '0;
      phase_d = 1'b0;
      bit_d   = '0;
    end else if (state_q != S_IDLE) begin
      if (half_end) begin
        div_d = '0;
        if (shifting) begin
          phase_d = ~phase_q;
          if (phase_q) bit_d = bit_q + BIT_ONE;
        end
      end else begin
        div_d = div_q + DIV_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs (registered below)
  // ---------------------------------------------------------------------------
  always_comb begin
    cs_d   = 1'b1;
    sclk_d = 1'b0;
    mosi_d = 1'b0;
    busy_d = (state_q != S_IDLE) || q_pending;
    done_d = (state_q == S_GAP) && (div_q == '0);
    unique case (state_q)
      S_ADDR: begin
        cs_d   = 1'b0;
        sclk_d = phase_q;
        mosi_d = (tx_idx == 3'd0) ? rw_q : addr_q[tx_idx - 3'd1];
      end
      S_TURNA: begin
        cs_d   = 1'b0;
        sclk_d = phase_q;
      end
      S_DATA: begin
        cs_d   = 1'b0;
        sclk_d = phase_q;
        mosi_d = rw_q ? 1'b0 : wdata_q[tx_idx];
      end
      S_HOLD: begin
        cs_d = 1'b0;
      end
      default: begin
        cs_d = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: request latch and receive shifter
  // ---------------------------------------------------------------------------
  assign load_req = (state_d == S_ADDR) &&
                    ((state_q == S_IDLE) || (state_q == S_GAP));

  always_comb begin
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (load_req) begin
      if (q_launch) begin
        rw_d    = q_rw;
        addr_d  = q_addr;
        wdata_d = q_wdata;
      end else begin
        rw_d    = rw;
        addr_d  = addr;
        wdata_d = wdata;
      end
    end
  end

  always_comb begin
    rx_d    = rx_q;
    rdata_d = rdata_q;
    if ((state_q == S_DATA) && rw_q && rise_next) begin
      rx_d = {rx_q[6:0], miso};
    end
    // rx_d (not rx_q) so that with CLK_DIV = 1 the last sampled bit, taken
    // at the same edge as the move to HOLD, is included.
    if ((state_q == S_DATA) && (state_d == S_HOLD) && rw_q) begin
      rdata_d = rx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cs        = cs_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for spi_master_ctrl. u_dut0 uses the default parameters
// (CLK_DIV=2, TURN=1), u_dut1 uses CLK_DIV=1, TURN=0. Cycle k is the clock
// period following the rising edge k; edge 0 is the edge that samples start.
// Inputs change 1 time unit after a rising edge, outputs are observed on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_spi_master_ctrl;

  localparam int NCYC = 150;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic       start0, start1;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;

  logic       busy0, done0, cs0, sclk0, mosi0, miso0;
  logic [7:0] rdata0;
  logic [2:0] dbg0;
  logic       busy1, done1, cs1, sclk1, mosi1, miso1;
  logic [7:0] rdata1;
  logic [2:0] dbg1;

  spi_master_ctrl #(.CLK_DIV(2), .TURN(1)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .rw(rw), .addr(addr),
    .wdata(wdata), .busy(busy0), .done(done0), .rdata(rdata0), .cs(cs0),
    .sclk(sclk0), .mosi(mosi0), .miso(miso0), .dbg_state(dbg0)
  );

  spi_master_ctrl #(.CLK_DIV(1), .TURN(0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .rw(rw), .addr(addr),
    .wdata(wdata), .busy(busy1), .done(done1), .rdata(rdata1), .cs(cs1),
    .sclk(sclk1), .mosi(mosi1), .miso(miso1), .dbg_state(dbg1)
  );

  // ---------------------------------------------------------------------------
  // Slave models: count SCLK rises while cs is low, present the read byte
  // MSB first once address and turnaround bits have gone by.
  // ---------------------------------------------------------------------------
  logic [7:0] sbyte0, sbyte1;
  int         cnt0, cnt1;
  logic       sclk0_p, sclk1_p;
  logic [2:0] sidx0, sidx1;

  initial begin
    sbyte0 = 8'h9E;
    sbyte1 = 8'h3C;
  end

  always @(negedge clk) begin
    if (cs0 !== 1'b0)              cnt0 <= 0;
    else if (sclk0 && !sclk0_p)    cnt0 <= cnt0 + 1;
    sclk0_p <= sclk0;
    if (cs1 !== 1'b0)              cnt1 <= 0;
    else if (sclk1 && !sclk1_p)    cnt1 <= cnt1 + 1;
    sclk1_p <= sclk1;
  end

  always_comb begin
    sidx0 = 3'(16 - cnt0);
    sidx1 = 3'(15 - cnt1);
    miso0 = 1'b0;
    miso1 = 1'b0;
    if ((cs0 === 1'b0) && (cnt0 >= 9) && (cnt0 < 17)) miso0 = sbyte0[sidx0];
    if ((cs1 === 1'b0) && (cnt1 >= 8) && (cnt1 < 16)) miso1 = sbyte1[sidx1];
  end

  // ---------------------------------------------------------------------------
  // Observation of the selected instance
  // ---------------------------------------------------------------------------
  logic sel;
  logic obs_cs, obs_sclk, obs_mosi, obs_busy, obs_done;
  logic [2:0] obs_dbg;

  assign obs_cs   = sel ? cs1   : cs0;
  assign obs_sclk = sel ? sclk1 : sclk0;
  assign obs_mosi = sel ? mosi1 : mosi0;
  assign obs_busy = sel ? busy1 : busy0;
  assign obs_done = sel ? done1 : done0;
  assign obs_dbg  = sel ? dbg1  : dbg0;

  logic       cs_log   [NCYC];
  logic       sclk_log [NCYC];
  logic       mosi_log [NCYC];
  logic       busy_log [NCYC];
  logic       done_log [NCYC];
  logic [2:0] dbg_log  [NCYC];

  int          rises;
  logic [63:0] bits;
  int          done_cnt;
  int          done_first;
  int          done_second;

  int checks;
  int errors;

  // ---------------------------------------------------------------------------
  // Driver: issue one request to instance s, then run NCYC cycles logging
  // outputs. Optionally assert reset for edge rst_at and issue a second
  // write request (a2/wd2) at edge st2_at. Between those, rw/addr/wdata are
  // scrambled so that only the values present at acceptance matter.
  // ---------------------------------------------------------------------------
  task automatic run_frame(input logic s, input logic r, input logic [6:0] a,
                           input logic [7:0] wd, input int rst_at,
                           input int st2_at, input logic [6:0] a2,
                           input logic [7:0] wd2);
    logic prev;
    sel         = s;
    rises       = 0;
    bits        = '0;
    done_cnt    = 0;
    done_first  = -1;
    done_second = -1;
    prev        = 1'b0;
    @(negedge clk);
    rw    = r;
    addr  = a;
    wdata = wd;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      reset  = 1'b0;
      rw     = 1'($urandom_range(0, 1));
      addr   = 7'($urandom_range(0, 127));
      wdata  = 8'($urandom_range(0, 255));
      if (k + 1 == rst_at) reset = 1'b1;
      if (k + 1 == st2_at) begin
        rw    = 1'b0;
        addr  = a2;
        wdata = wd2;
        if (s) start1 = 1'b1; else start0 = 1'b1;
      end
      @(negedge clk);
      cs_log[k]   = obs_cs;
      sclk_log[k] = obs_sclk;
      mosi_log[k] = obs_mosi;
      busy_log[k] = obs_busy;
      done_log[k] = obs_done;
      dbg_log[k]  = obs_dbg;
      if (obs_sclk && !prev) begin
        rises++;
        bits = {bits[62:0], obs_mosi};
      end
      prev = obs_sclk;
      if (obs_done) begin
        done_cnt++;
        if (done_first < 0)       done_first  = k;
        else if (done_second < 0) done_second = k;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    rw     = 1'b0;
    addr   = '0;
    wdata  = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({cs0, sclk0, mosi0, busy0, done0} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl0: got %b expected 10000", {cs0, sclk0, mosi0, busy0, done0});
    end
    checks++;
    if (rdata0 !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata0: got %h expected 00", rdata0);
    end
    checks++;
    if (dbg0 !== 3'd0) begin
      errors++;
      $display("FAIL reset_state0: got %0d expected 0", dbg0);
    end
    checks++;
    if ({cs1, sclk1, mosi1, busy1, done1, rdata1} !== {5'b10000, 8'h00}) begin
      errors++;
      $display("FAIL reset_ctrl1: got %b expected 1000000000000",
               {cs1, sclk1, mosi1, busy1, done1, rdata1});
    end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_write();
    run_frame(1'b0, 1'b0, 7'h2A, 8'hC3, -1, -1, 7'h00, 8'h00);
    checks++;
    if (bits[15:0] !== 16'h54C3) begin
      errors++;
      $display("FAIL write_mosi: got %h expected 54c3", bits[15:0]);
    end
    checks++;
    if (rises !== 16) begin
      errors++;
      $display("FAIL write_rises: got %0d expected 16", rises);
    end
    checks++;
    if (done_first !== 67 || done_cnt !== 1) begin
      errors++;
      $display("FAIL write_done: got cycle %0d count %0d expected cycle 67 count 1",
               done_first, done_cnt);
    end
    checks++;
    if ({cs_log[0], cs_log[1], cs_log[66], cs_log[67]} !== 4'b1001) begin
      errors++;
      $display("FAIL write_cs: got %b expected 1001",
               {cs_log[0], cs_log[1], cs_log[66], cs_log[67]});
    end
    checks++;
    if ({busy_log[0], busy_log[1], busy_log[68], busy_log[69]} !== 4'b0110) begin
      errors++;
      $display("FAIL write_busy: got %b expected 0110",
               {busy_log[0], busy_log[1], busy_log[68], busy_log[69]});
    end
    checks++;
    if (rdata0 !== 8'h00) begin
      errors++;
      $display("FAIL write_rdata: got %h expected 00", rdata0);
    end
  endtask

  task automatic test_read();
    run_frame(1'b0, 1'b1, 7'h05, 8'hFF, -1, -1, 7'h00, 8'h00);
    checks++;
    if (rises !== 17) begin
      errors++;
      $display("FAIL read_rises: got %0d expected 17", rises);
    end
    checks++;
    if (bits[16:0] !== 17'h01600) begin
      errors++;
      $display("FAIL read_mosi: got %h expected 01600", bits[16:0]);
    end
    checks++;
    if (rdata0 !== 8'h9E) begin
      errors++;
      $display("FAIL read_rdata: got %h expected 9e", rdata0);
    end
    checks++;
    if (done_first !== 71 || done_cnt !== 1) begin
      errors++;
      $display("FAIL read_done: got cycle %0d count %0d expected cycle 71 count 1",
               done_first, done_cnt);
    end
    checks++;
    if ({busy_log[72], busy_log[73]} !== 2'b10) begin
      errors++;
      $display("FAIL read_busy_fall: got %b expected 10", {busy_log[72], busy_log[73]});
    end
  endtask

  task automatic test_fast_read();
    int bad;
    run_frame(1'b1, 1'b1, 7'h40, 8'h00, -1, -1, 7'h00, 8'h00);
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      if (sclk_log[k] !== ((k % 2) == 0)) bad++;
      if (cs_log[k] !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL fast_sclk: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (done_first !== 34 || done_cnt !== 1) begin
      errors++;
      $display("FAIL fast_done: got cycle %0d count %0d expected cycle 34 count 1",
               done_first, done_cnt);
    end
    checks++;
    if (rises !== 16 || bits[15:0] !== 16'h8100) begin
      errors++;
      $display("FAIL fast_mosi: got %0d rises bits %h expected 16 rises bits 8100",
               rises, bits[15:0]);
    end
    checks++;
    if (rdata1 !== 8'h3C) begin
      errors++;
      $display("FAIL fast_rdata: got %h expected 3c", rdata1);
    end
  endtask

  task automatic test_back_to_back();
    int low;
    run_frame(1'b0, 1'b0, 7'h2A, 8'hC3, -1, 10, 7'h11, 8'h77);
    checks++;
    if (rdata0 !== 8'h9E) begin
      errors++;
      $display("FAIL b2b_rdata: got %h expected 9e", rdata0);
    end
`ifdef SPI_MASTER_CTRL_QUEUE_EN
    checks++;
    if (done_cnt !== 2 || done_first !== 67 || done_second !== 135) begin
      errors++;
      $display("FAIL b2b_done: got count %0d at %0d,%0d expected 2 at 67,135",
               done_cnt, done_first, done_second);
    end
    checks++;
    if (rises !== 32 || bits[31:0] !== 32'h54C32277) begin
      errors++;
      $display("FAIL b2b_mosi: got %0d rises bits %h expected 32 rises bits 54c32277",
               rises, bits[31:0]);
    end
    low = 0;
    for (int k = 1; k <= 136; k++) if (busy_log[k] !== 1'b1) low++;
    checks++;
    if (low !== 0 || busy_log[137] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy: got %0d low cycles, busy137=%b expected 0 and 0",
               low, busy_log[137]);
    end
`else
    low = 0;
    checks++;
    if (done_cnt !== 1 || done_first !== 67) begin
      errors++;
      $display("FAIL b2b_done: got count %0d at %0d expected 1 at 67",
               done_cnt, done_first);
    end
    checks++;
    if (rises !== 16 || bits[15:0] !== 16'h54C3) begin
      errors++;
      $display("FAIL b2b_mosi: got %0d rises bits %h expected 16 rises bits 54c3",
               rises, bits[15:0]);
    end
    checks++;
    if (busy_log[69] !== 1'b0 || cs_log[100] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle: got busy69=%b cs100=%b expected 0 1",
               busy_log[69], cs_log[100]);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    run_frame(1'b0, 1'b0, 7'h2A, 8'hC3, 20, 23, 7'h33, 8'h5A);
    checks++;
    if ({cs_log[21], sclk_log[21], mosi_log[21], busy_log[21], done_log[21]} !== 5'b10000) begin
      errors++;
      $display("FAIL midrst_ctrl: got %b expected 10000",
               {cs_log[21], sclk_log[21], mosi_log[21], busy_log[21], done_log[21]});
    end
    checks++;
    if (dbg_log[21] !== 3'd0) begin
      errors++;
      $display("FAIL midrst_state: got %0d expected 0", dbg_log[21]);
    end
    checks++;
    if (done_cnt !== 1 || done_first !== 90) begin
      errors++;
      $display("FAIL midrst_done: got count %0d at %0d expected 1 at 90",
               done_cnt, done_first);
    end
    checks++;
    if (rises !== 21 || bits[15:0] !== 16'h665A || cs_log[24] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_frame: got %0d rises bits %h cs24=%b expected 21 665a 0",
               rises, bits[15:0], cs_log[24]);
    end
    checks++;
    if (rdata0 !== 8'h00) begin
      errors++;
      $display("FAIL midrst_rdata: got %h expected 00", rdata0);
    end
  endtask

  task automatic test_start_with_reset();
    int bad;
    bad = 0;
    @(negedge clk);
    rw     = 1'b1;
    addr   = 7'h7F;
    wdata  = 8'hAA;
    start0 = 1'b1;
    reset  = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      start0 = 1'b0;
      reset  = 1'b0;
      @(negedge clk);
      if (cs0 !== 1'b1 || busy0 !== 1'b0 || dbg0 !== 3'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL start_reset: got %0d active cycles expected 0", bad);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    checks = 0;
    errors = 0;
    sel    = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_fast_read();
    test_back_to_back();
    test_reset_mid_frame();
    test_start_with_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Host-side controller that sequences complete transactions to the SPI memory slave. It accepts a single-cycle request carrying an address, a read/write flag and write data. It generates CS, SCLK and MOSI for one 16-bit-plus-turnaround frame, captures MISO on reads, and reports completion with a one-cycle `done` pulse. It is the only block that drives the slave's `CS` and `s_clk` pins.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per SCLK half-period; legal range ≥1.
- `TURN`, 1: SCLK cycles of turnaround between the address byte and read data; legal range ≥0; has no effect on writes.

Ports:
- `clk`, in, 1: system clock. Everything is sampled on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: request strobe. Accepted when `busy`=0.
- `rw`, in, 1: 1=read, 0=write. Captured with `start`.
- `addr`, in, 7: memory address. Captured with `start`.
- `wdata`, in, 8: write data. Captured with `start`.
- `busy`, out, 1: high from the cycle after acceptance until the end of the CS gap.
- `done`, out, 1: one-cycle pulse at frame end.
- `rdata`, out, 8: read result. Valid with `done`; held until the next read completes.
- `cs`, out, 1: slave chip select, active-low.
- `sclk`, out, 1: serial clock. Idles low.
- `mosi`, out, 1: serial data to the slave.
- `miso`, in, 1: serial data from the slave.

## Operation
- States: IDLE, ADDR, TURNA, DATA, HOLD, GAP.
- IDLE: `cs`=1, `sclk`=0, `mosi`=0. On `start`, latch `rw`/`addr`/`wdata` and go to ADDR.
- ADDR: shift out 8 bits MSB-first: `addr[6:0]`, then `rw`.
  - After bit 7: a read goes to TURNA, or straight to DATA if `TURN`=0. A write goes to DATA.
- TURNA: `TURN` full SCLK cycles with `mosi`=0.
- DATA, write: shift out `wdata[7:0]` MSB-first.
- DATA, read: `mosi`=0. Sample `miso` on each SCLK rise into a shift register MSB-first. Copy it to `rdata` when entering HOLD.
- HOLD: `cs` stays 0 and `sclk` stays 0 for `CLK_DIV` clocks.
- GAP: `cs`=1 for `CLK_DIV` clocks. `done`=1 in the first GAP cycle. Then return to IDLE.
- Bit timing (SPI mode 0): each bit is a low phase of `CLK_DIV` clocks followed by a high phase of `CLK_DIV` clocks.
  - `mosi` updates on the first clock of the low phase.
  - `miso` is sampled on the clock edge at which `sclk` goes 0→1.
- Counters: a half-period divider counts 0..`CLK_DIV`-1; a bit counter counts 0..7 per phase. Both clear on every state entry.
- Boundary rules:
  - `start` while `busy`=1: ignored, unless the macro below is defined.
  - `reset` together with `start`: reset wins; no request is latched.
  - `reset` mid-frame: the next cycle has `cs`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, state IDLE. The partial frame is abandoned with no `done`.
  - Write: `rdata` is unchanged.
  - `rw`/`addr`/`wdata` changes after acceptance have no effect.

## Timing
- Reset values: `cs`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `rdata`=0.
- All outputs are registered.
- Latency counts from the clock edge that samples `start` (cycle 0). `cs` falls in cycle 1.
- Write: `done` in cycle 1 + 33·`CLK_DIV`. With defaults: cycle 67.
- Read: `done` in cycle 1 + (33 + 2·`TURN`)·`CLK_DIV`. With defaults: cycle 71.
- `busy` falls `CLK_DIV` cycles after `done`. A new `start` is accepted on the first cycle with `busy`=0.

## Configuration
- Macro: `SPI_MASTER_CTRL_QUEUE_EN`.
- Defined: adds a one-entry request buffer.
  - `start` while `busy`=1 and the buffer is empty stores the request.
  - `start` while the buffer is full is dropped.
  - A buffered request launches in the cycle GAP ends: `cs` falls the next cycle, and `busy` stays high continuously.
  - `reset` clears the buffer.
- Undefined: no buffer. `start` while busy is ignored, per Operation.

## Test plan
- Write, defaults: `start`, `rw`=0, `addr`=0x2A, `wdata`=0xC3.
  - Required: the MOSI bits sampled at SCLK rises are 0101010_0 then 11000011.
  - Required: 16 SCLK rises; `done` at cycle 67; `rdata` unchanged.
- Read, defaults: `rw`=1, `addr`=0x05; the slave model drives 0x9E starting after the turnaround.
  - Required: 17 SCLK rises, `rdata`=0x9E, `done` at cycle 71.
- `CLK_DIV`=1, `TURN`=0, read:
  - Required: `sclk` toggles every clock; `done` at cycle 34.
- Assert `reset` at cycle 20 of a write.
  - Required: `cs`=1 and `sclk`=0 at cycle 21; no `done`.
  - Required: a new `start` at cycle 23 produces a full, correct frame.
- Second `start` (`addr`=0x11) at cycle 10 of a write:
  - Macro undefined: ignored, exactly one `done`.
  - Macro defined: second frame follows, two `done` pulses, `busy` never low between them.
- `start` and `reset` in the same cycle:
  - Required: `cs` stays 1 and `busy` stays 0.
